// File: rtl/spike_router.sv
// N-core spike interconnect: address-decoded routing, per-destination round-robin
// arbitration and a show-ahead FIFO per destination core.
module spike_router #(
  parameter int unsigned N_CORES    = 2,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned LOCAL_W    = 1,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [N_CORES-1:0]                          src_valid,
  input  logic [N_CORES*ADDR_W-1:0]                   src_addr,
  input  logic [N_CORES*DATA_W-1:0]                   src_data,
  output logic [N_CORES-1:0]                          src_ready,
  output logic [N_CORES-1:0]                          dst_valid,
  output logic [N_CORES*ADDR_W-1:0]                   dst_addr,
  output logic [N_CORES*DATA_W-1:0]                   dst_data,
  input  logic [N_CORES-1:0]                          dst_ready,
  output logic [N_CORES-1:0]                          drop_err,
  output logic [N_CORES*($clog2(FIFO_DEPTH)+1)-1:0]   fifo_count
);

  localparam int unsigned DestW = ADDR_W - LOCAL_W;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned SrcW  = $clog2(N_CORES);
  localparam int unsigned PktW  = ADDR_W + DATA_W;
  localparam int          NC    = int'(N_CORES);

  logic [DestW-1:0]   dest    [N_CORES];
  logic [N_CORES-1:0] dest_ok;
  logic [N_CORES-1:0] req     [N_CORES];  // req[d][i]: source i wants destination d
  logic [N_CORES-1:0] gnt     [N_CORES];
  logic [PktW-1:0]    win_pkt [N_CORES];
  logic [N_CORES-1:0] push, pop, full, empty;

  logic [SrcW-1:0]    rr_q     [N_CORES];
  logic [SrcW-1:0]    rr_d     [N_CORES];
  logic [PtrW-1:0]    wr_ptr_q [N_CORES];
  logic [PtrW-1:0]    wr_ptr_d [N_CORES];
  logic [PtrW-1:0]    rd_ptr_q [N_CORES];
  logic [PtrW-1:0]    rd_ptr_d [N_CORES];
  logic [CntW-1:0]    cnt_q    [N_CORES];
  logic [CntW-1:0]    cnt_d    [N_CORES];
  logic [PktW-1:0]    mem_q    [N_CORES][FIFO_DEPTH];
  logic [PktW-1:0]    mem_d    [N_CORES][FIFO_DEPTH];
  logic [N_CORES-1:0] drop_err_q, drop_err_d;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      dest[i]    = src_addr[i*ADDR_W + LOCAL_W +: DestW];
      dest_ok[i] = int'(dest[i]) < NC;
    end
  end

  // Two passes give the wrap-around scan: first sources at/after rr, then those below it.
  always_comb begin
    for (int d = 0; d < NC; d++) begin
      logic found;
      req[d]     = '0;
      gnt[d]     = '0;
      win_pkt[d] = '0;
      found      = 1'b0;
      for (int i = 0; i < NC; i++) begin
        req[d][i] = src_valid[i] & dest_ok[i] & (int'(dest[i]) == d);
      end
      for (int i = 0; i < NC; i++) begin
        if (!found && req[d][i] && (i >= int'(rr_q[d]))) begin
          gnt[d][i] = 1'b1;
          found     = 1'b1;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (!found && req[d][i] && (i < int'(rr_q[d]))) begin
          gnt[d][i] = 1'b1;
          found     = 1'b1;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (gnt[d][i]) begin
          win_pkt[d] = {src_addr[i*ADDR_W +: ADDR_W], src_data[i*DATA_W +: DATA_W]};
        end
      end
      full[d]  = cnt_q[d] == CntW'(FIFO_DEPTH);
      empty[d] = cnt_q[d] == '0;
      push[d]  = (|gnt[d]) & ~full[d] & reset;
      pop[d]   = ~empty[d] & dst_ready[d];
    end
  end

  // Invalid destinations are swallowed immediately and flagged per source.
  always_comb begin
    src_ready  = '0;
    drop_err_d = drop_err_q;
    for (int i = 0; i < NC; i++) begin
      if (!dest_ok[i]) begin
        src_ready[i]  = reset;
        drop_err_d[i] = drop_err_q[i] | src_valid[i];
      end else begin
        for (int d = 0; d < NC; d++) begin
          if (gnt[d][i] && !full[d]) src_ready[i] = reset;
        end
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int d = 0; d < NC; d++) begin
      rr_d[d]     = rr_q[d];
      wr_ptr_d[d] = wr_ptr_q[d];
      rd_ptr_d[d] = rd_ptr_q[d];
      cnt_d[d]    = cnt_q[d];
      if (push[d]) begin
        mem_d[d][wr_ptr_q[d]] = win_pkt[d];
        wr_ptr_d[d]           = wr_ptr_q[d] + PtrW'(1);
        for (int i = 0; i < NC; i++) begin
          if (gnt[d][i]) rr_d[d] = (i == NC - 1) ? '0 : SrcW'(i + 1);
        end
      end
      if (pop[d]) rd_ptr_d[d] = rd_ptr_q[d] + PtrW'(1);
      unique case ({push[d], pop[d]})
        2'b10:   cnt_d[d] = cnt_q[d] + CntW'(1);
        2'b01:   cnt_d[d] = cnt_q[d] - CntW'(1);
        default: cnt_d[d] = cnt_q[d];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < NC; d++) begin
        rr_q[d]     <= '0;
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        cnt_q[d]    <= '0;
      end
      drop_err_q <= '0;
    end else begin
      for (int d = 0; d < NC; d++) begin
        rr_q[d]     <= rr_d[d];
        wr_ptr_q[d] <= wr_ptr_d[d];
        rd_ptr_q[d] <= rd_ptr_d[d];
        cnt_q[d]    <= cnt_d[d];
      end
      drop_err_q <= drop_err_d;
    end
  end

  // Payload storage needs no reset; heads are qualified by dst_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    dst_valid  = '0;
    dst_addr   = '0;
    dst_data   = '0;
    fifo_count = '0;
    for (int d = 0; d < NC; d++) begin
      dst_valid[d]                  = ~empty[d];
      dst_addr[d*ADDR_W +: ADDR_W]  = mem_q[d][rd_ptr_q[d]][PktW-1 -: ADDR_W];
      dst_data[d*DATA_W +: DATA_W]  = mem_q[d][rd_ptr_q[d]][DATA_W-1:0];
      fifo_count[d*CntW +: CntW]    = cnt_q[d];
    end
  end

  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_spike_router.sv
// Directed bench for spike_router: a default 2-core instance and a 3-core instance
// used for invalid-destination handling.
module tb_spike_router;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  s2_valid, s2_ready, d2_valid, d2_ready, d2_err;
  logic [3:0]  s2_addr, d2_addr;
  logic [63:0] s2_data, d2_data;
  logic [5:0]  d2_cnt;

  logic [2:0]  s3_valid, s3_ready, d3_valid, d3_ready, d3_err;
  logic [8:0]  s3_addr, d3_addr, d3_cnt;
  logic [95:0] s3_data, d3_data;

  int tests_run = 0;
  int tests_failed = 0;

  spike_router u_dut2 (
    .clk(clk), .reset(reset),
    .src_valid(s2_valid), .src_addr(s2_addr), .src_data(s2_data), .src_ready(s2_ready),
    .dst_valid(d2_valid), .dst_addr(d2_addr), .dst_data(d2_data), .dst_ready(d2_ready),
    .drop_err(d2_err), .fifo_count(d2_cnt)
  );

  spike_router #(.N_CORES(3), .ADDR_W(3), .LOCAL_W(1), .DATA_W(32), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .src_valid(s3_valid), .src_addr(s3_addr), .src_data(s3_data), .src_ready(s3_ready),
    .dst_valid(d3_valid), .dst_addr(d3_addr), .dst_data(d3_data), .dst_ready(d3_ready),
    .drop_err(d3_err), .fifo_count(d3_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    s2_valid = '0; s2_addr = '0; s2_data = '0; d2_ready = '0;
    s3_valid = '0; s3_addr = '0; s3_data = '0; d3_ready = '0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    s2_valid = 2'b11; s2_addr = 4'b0000;
    s3_valid = 3'b111; s3_addr = 9'b111_000_000;
    tick(); tick();
    @(negedge clk);
    tests_run++; if (s2_ready !== 2'b00) begin tests_failed++;
      $display("FAIL reset_src_ready: got %b want 00", s2_ready); end
    tests_run++; if (d2_valid !== 2'b00) begin tests_failed++;
      $display("FAIL reset_dst_valid: got %b want 00", d2_valid); end
    tests_run++; if (d2_cnt !== 6'd0) begin tests_failed++;
      $display("FAIL reset_fifo_count: got %h want 0", d2_cnt); end
    tests_run++; if (d2_err !== 2'b00) begin tests_failed++;
      $display("FAIL reset_drop_err: got %b want 00", d2_err); end
    tests_run++; if (s3_ready !== 3'b000) begin tests_failed++;
      $display("FAIL reset_invalid_ready: got %b want 000", s3_ready); end
    tests_run++; if (d3_err !== 3'b000) begin tests_failed++;
      $display("FAIL reset_drop_err3: got %b want 000", d3_err); end
    tick();
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_parallel;
    s2_valid = 2'b11;
    s2_addr  = {2'b00, 2'b10};
    s2_data  = {32'hABAB_ABAB, 32'hA5A5_A5A5};
    d2_ready = 2'b00;
    @(negedge clk);
    tests_run++; if (s2_ready !== 2'b11) begin tests_failed++;
      $display("FAIL par_src_ready: got %b want 11", s2_ready); end
    tests_run++; if (d2_valid !== 2'b00) begin tests_failed++;
      $display("FAIL par_not_yet_valid: got %b want 00", d2_valid); end
    tick();
    s2_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (d2_valid !== 2'b11) begin tests_failed++;
      $display("FAIL par_dst_valid: got %b want 11", d2_valid); end
    tests_run++; if (d2_addr !== 4'b1000) begin tests_failed++;
      $display("FAIL par_dst_addr: got %b want 1000", d2_addr); end
    tests_run++; if (d2_data !== {32'hA5A5_A5A5, 32'hABAB_ABAB}) begin tests_failed++;
      $display("FAIL par_dst_data: got %h want a5a5a5a5abababab", d2_data); end
    tests_run++; if (d2_cnt !== {3'd1, 3'd1}) begin tests_failed++;
      $display("FAIL par_count: got %h want 09", d2_cnt); end
    d2_ready = 2'b11;
    tick();
    d2_ready = 2'b00;
    @(negedge clk);
    tests_run++; if (d2_cnt !== 6'd0 || d2_valid !== 2'b00) begin tests_failed++;
      $display("FAIL par_drain: got cnt %h valid %b want 0 00", d2_cnt, d2_valid); end
    tick();
  endtask

  task automatic test_contention;
    int n0, n1;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_dat;
    n0 = 0; n1 = 0;
    do_reset();
    s2_valid = 2'b11; s2_addr = 4'b0000; d2_ready = 2'b01;
    for (int k = 0; k < 8; k++) begin
      s2_data = {32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)};
      @(negedge clk);
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests_run++; if (s2_ready !== exp_rdy) begin tests_failed++;
        $display("FAIL cont_grant[%0d]: got %b want %b", k, s2_ready, exp_rdy); end
      if (s2_ready[0]) n0++;
      if (s2_ready[1]) n1++;
      if (k > 0) begin
        exp_dat = (((k - 1) % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(k - 1);
        tests_run++; if (d2_data[31:0] !== exp_dat) begin tests_failed++;
          $display("FAIL cont_head[%0d]: got %h want %h", k, d2_data[31:0], exp_dat); end
      end
      tick();
    end
    tests_run++; if (n0 != 4 || n1 != 4) begin tests_failed++;
      $display("FAIL cont_share: got %0d/%0d want 4/4", n0, n1); end
    idle_inputs();
  endtask

  task automatic test_full;
    int pushed, popped;
    pushed = 0; popped = 0;
    do_reset();
    s2_valid = 2'b01; s2_addr = 4'b0000; d2_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      s2_data[31:0] = 32'hC0 + 32'(pushed);
      @(negedge clk);
      tests_run++; if (s2_ready[0] !== 1'b1) begin tests_failed++;
        $display("FAIL full_fill[%0d]: got ready %b want 1", k, s2_ready[0]); end
      tick();
      pushed++;
    end
    s2_data[31:0] = 32'hC0 + 32'(pushed);
    @(negedge clk);
    tests_run++; if (d2_cnt[2:0] !== 3'd4 || s2_ready[0] !== 1'b0) begin tests_failed++;
      $display("FAIL full_block: got cnt %0d ready %b want 4 0", d2_cnt[2:0], s2_ready[0]); end
    tick();
    d2_ready = 2'b01;
    @(negedge clk);
    tests_run++; if (s2_ready[0] !== 1'b0 || d2_data[31:0] !== 32'hC0) begin tests_failed++;
      $display("FAIL full_pop_only: got ready %b head %h want 0 c0", s2_ready[0], d2_data[31:0]); end
    tick();
    popped = 1;
    d2_ready = 2'b00;
    @(negedge clk);
    tests_run++; if (d2_cnt[2:0] !== 3'd3 || s2_ready[0] !== 1'b1) begin tests_failed++;
      $display("FAIL full_after_pop: got cnt %0d ready %b want 3 1", d2_cnt[2:0], s2_ready[0]); end
    tick();
    pushed++;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (popped >= 10) break;
      s2_valid[0]   = (pushed < 10);
      s2_data[31:0] = 32'hC0 + 32'(pushed);
      d2_ready[0]   = (cyc % 3 != 2);
      @(negedge clk);
      if (s2_valid[0] && s2_ready[0]) pushed++;
      if (d2_valid[0] && d2_ready[0]) begin
        tests_run++; if (d2_data[31:0] !== 32'hC0 + 32'(popped)) begin tests_failed++;
          $display("FAIL full_order[%0d]: got %h want %h", popped, d2_data[31:0],
                   32'hC0 + 32'(popped)); end
        popped++;
      end
      tick();
    end
    tests_run++; if (popped != 10) begin tests_failed++;
      $display("FAIL full_drain_total: got %0d want 10", popped); end
    idle_inputs();
  endtask

  task automatic test_bad_dest;
    do_reset();
    s3_valid = 3'b101;
    s3_addr  = {3'b111, 3'b000, 3'b101};
    s3_data  = {32'h0, 32'h0, 32'h33};
    @(negedge clk);
    tests_run++; if (s3_ready !== 3'b101) begin tests_failed++;
      $display("FAIL bad_ready: got %b want 101", s3_ready); end
    tests_run++; if (d3_err !== 3'b000) begin tests_failed++;
      $display("FAIL bad_err_early: got %b want 000", d3_err); end
    tick();
    s3_valid = 3'b000;
    @(negedge clk);
    tests_run++; if (d3_err !== 3'b100) begin tests_failed++;
      $display("FAIL bad_err_set: got %b want 100", d3_err); end
    tests_run++; if (d3_valid !== 3'b100 || d3_addr[8:6] !== 3'b101) begin tests_failed++;
      $display("FAIL bad_good_route: got valid %b addr %b want 100 101", d3_valid, d3_addr[8:6]); end
    tests_run++; if (d3_cnt !== {3'd1, 3'd0, 3'd0}) begin tests_failed++;
      $display("FAIL bad_not_enqueued: got %h want 040", d3_cnt); end
    tick(); tick(); tick();
    @(negedge clk);
    tests_run++; if (d3_err !== 3'b100) begin tests_failed++;
      $display("FAIL bad_err_sticky: got %b want 100", d3_err); end
    tick();
    do_reset();
    @(negedge clk);
    tests_run++; if (d3_err !== 3'b000 || d3_valid !== 3'b000) begin tests_failed++;
      $display("FAIL bad_err_cleared: got err %b valid %b want 000 000", d3_err, d3_valid); end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    s2_valid = 2'b01; s2_addr = 4'b0000; s2_data = 64'h1;
    tick();
    s2_addr = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    s2_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (d2_cnt !== {3'd3, 3'd1}) begin tests_failed++;
      $display("FAIL mid_pre_count: got %h want 19", d2_cnt); end
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    s2_valid = 2'b11; s2_addr = 4'b0000;
    @(negedge clk);
    tests_run++; if (d2_cnt !== 6'd0 || d2_valid !== 2'b00) begin tests_failed++;
      $display("FAIL mid_flushed: got cnt %h valid %b want 0 00", d2_cnt, d2_valid); end
    tests_run++; if (s2_ready !== 2'b01) begin tests_failed++;
      $display("FAIL mid_rr_reset: got %b want 01", s2_ready); end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_parallel();
    test_contention();
    test_full();
    test_bad_dest();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spike_router.md
# spike_router

Parametrised N-core spike interconnect that replaces the fixed two-core interconnect. Each core presents a global neuron address plus a data word on a valid/ready source port. The router decodes the destination core from the address MSBs and arbitrates round-robin among sources contending for the same destination. Each accepted packet is buffered in that destination's FIFO, which drains to the core's sink port.

## Interface
- `N_CORES`, 2: number of cores; ≥2.
- `ADDR_W`, 2: global neuron address width.
- `LOCAL_W`, 1: low address bits that index a neuron inside a core. Destination = `addr[ADDR_W-1:LOCAL_W]`. `ADDR_W-LOCAL_W` ≥ clog2(`N_CORES`).
- `DATA_W`, 32: payload width.
- `FIFO_DEPTH`, 4: entries per destination FIFO; power of two, ≥2.

Ports (vectors are flattened; core i occupies slice i):
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `src_valid` input N_CORES: core i offers a packet.
- `src_addr` input N_CORES*ADDR_W: destination neuron address.
- `src_data` input N_CORES*DATA_W: payload.
- `src_ready` output N_CORES: packet accepted this cycle when high with `src_valid`.
- `dst_valid` output N_CORES: destination FIFO i is non-empty.
- `dst_addr` output N_CORES*ADDR_W: head packet address (full global address).
- `dst_data` output N_CORES*DATA_W: head packet payload.
- `dst_ready` input N_CORES: core i consumes the head this cycle.
- `drop_err` output N_CORES: sticky flag; source i sent to a non-existent core.
- `fifo_count` output N_CORES*(clog2(FIFO_DEPTH)+1): occupancy of each destination FIFO.

## Operation
- Decode: `dest_i = src_addr_i[ADDR_W-1:LOCAL_W]`. If `dest_i ≥ N_CORES` the request is invalid. Invalid requests are accepted immediately (`src_ready=1`), discarded, and set `drop_err[i]`. They never participate in arbitration.
- Arbitration: each destination d has its own round-robin pointer `rr[d]`, holding a source index.
  - Among valid sources with `dest==d`, grant the first at or after `rr[d]`, scanning upward and wrapping from N_CORES-1 to 0.
  - At most one grant per destination per cycle. Different destinations are granted in parallel.
- `src_ready[i] = granted_i & !full[dest_i]`, or 1 for an invalid request. The signal is combinational from inputs and state and does not depend on `src_ready`.
- Pointer update: on an accepted push from source w into d, `rr[d] <= (w+1) mod N_CORES`. With no push, `rr[d]` holds.
- FIFO: show-ahead, one per destination. Push on accepted grant; pop on `dst_valid & dst_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full/empty:
  - Full blocks push even if a pop occurs the same cycle; there is no pass-through.
  - Push to an empty FIFO is not visible on `dst_valid` until the next cycle.
  - `dst_ready` while empty is ignored and count stays 0.
- Self-traffic: a source addressing its own core is routed like any other packet.
- `drop_err` clears only on reset.

## Timing
- Reset (`reset==0` at edge): all FIFOs empty, counts 0, every `rr[d]=0`, `drop_err=0`. Hence `dst_valid=0`. `dst_addr`/`dst_data` read from the head slot (contents unspecified) and are qualified by `dst_valid`.
  - `src_ready` is forced 0 while `reset==0`, including for invalid requests.
  - A packet in flight when reset asserts is lost. Reset mid-operation discards all FIFO contents.
- Latency: a push accepted at edge t gives `dst_valid=1` with that packet in the cycle after t, provided the FIFO was empty. Otherwise the packet appears behind earlier entries in FIFO order.
- Throughput: one packet per destination per cycle; N_CORES packets per cycle when destinations are distinct.
- A stalled source may change `addr`/`data` while `src_ready=0`. No hold requirement is imposed on the source.

## Test plan
- Reset, N_CORES=2: hold `reset=0` for 2 cycles with `src_valid=2'b11` -> `src_ready=0`, `dst_valid=0`, counts 0, `drop_err=0`.
- Parallel routing: src0 addr 2'b10 data A5A5A5A5, src1 addr 2'b00 data ABABABAB, one cycle -> next cycle `dst_valid=2'b11`; dst1 holds (10, A5A5A5A5) and dst0 holds (00, ABABABAB). Latency is 1 cycle.
- Contention: both sources target core 0 continuously with `dst_ready=1` -> grants alternate src0, src1, src0, … starting with src0 after reset. Each source gets exactly 4 of 8 consecutive cycles.
- Full/back-pressure, FIFO_DEPTH=4, `dst_ready[0]=0`: 4 pushes into core 0 -> count 4 and `src_ready=0` on the 5th. Then `dst_ready[0]=1` with a push offered -> pop only that cycle, count 3, push accepted the next cycle. Data order is preserved across pointer wrap for 10 packets.
- Bad destination, N_CORES=3, ADDR_W=3, LOCAL_W=1: src2 addr 3'b111 -> `src_ready[2]=1` the same cycle, nothing enqueued, `drop_err[2]` set and sticky until reset.
- Reset mid-stream: core 1 FIFO holding 3 entries, `reset=0` for one cycle -> count 0, `dst_valid=0`, `rr` back to 0. The first post-reset contention is granted to src0.
